// File: rtl/d_ff.sv
// Positive-edge storage cell with asynchronous active-low clear.
// Pipeline registers replicate the default one-bit cell, one instance per bit.
module d_ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = d;

  // Reset is sensed on its falling edge so the clear never waits for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_d_ff.sv
// Directed bench: one-bit cell, a five-cell pipeline register and an 8-bit
// instance with a non-zero reset value, all sharing one clock and reset.
module tb_d_ff;

  logic       clk;
  logic       reset;
  logic       d1;
  logic       q1;
  logic [4:0] d5;
  logic [4:0] q5;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks;
  int errors;

  d_ff u_bit (
    .clk   (clk),
    .reset (reset),
    .d     (d1),
    .q     (q1)
  );

  for (genvar g = 0; g < 5; g++) begin : gen_pipe
    d_ff u_cell (
      .clk   (clk),
      .reset (reset),
      .d     (d5[g]),
      .q     (q5[g])
    );
  end

  d_ff #(.WIDTH(8), .RESET_VAL(8'hA5)) u_wide (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] vecs [4];
    logic [4:0] prev;
    checks = 0;
    errors = 0;
    vecs[0] = 5'b11111;
    vecs[1] = 5'b00000;
    vecs[2] = 5'b10101;
    vecs[3] = 5'b11110;

    clk   = 1'b0;
    reset = 1'b1;
    d1    = 1'b1;
    d5    = 5'b11111;
    d8    = 8'hFF;
    #2;

    // Asynchronous clear with no clock activity
    reset = 1'b0;
    #1;
    check("rst_q1", {7'b0, q1}, 8'h00);
    check("rst_q5", {3'b0, q5}, 8'h00);
    check("rst_q8", q8, 8'hA5);

    repeat (3) begin
      clk = 1'b1; #5;
      clk = 1'b0; #5;
    end
    check("rst_clk_q1", {7'b0, q1}, 8'h00);
    check("rst_clk_q8", q8, 8'hA5);

    // Basic capture, falling edge ignored
    reset = 1'b1;
    #2;
    d1 = 1'b1;
    #3;
    clk = 1'b1; #1;
    check("cap1", {7'b0, q1}, 8'h01);
    d1 = 1'b0;
    #4;
    clk = 1'b0; #1;
    check("fall_hold", {7'b0, q1}, 8'h01);
    #4;
    clk = 1'b1; #1;
    check("cap0", {7'b0, q1}, 8'h00);

    // Idle clock low for three periods
    #4;
    clk = 1'b0;
    #2;
    d1 = 1'b1;
    #30;
    check("idle_hold", {7'b0, q1}, 8'h00);
    clk = 1'b1; #1;
    check("idle_cap", {7'b0, q1}, 8'h01);
    #4;
    clk = 1'b0;
    #2;

    // Five-cell pipeline register
    reset = 1'b0;
    #1;
    check("pipe_rst", {3'b0, q5}, 8'h00);
    reset = 1'b1;
    #2;
    prev = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      d5 = vecs[i];
      #2;
      check($sformatf("pipe_between%0d", i), {3'b0, q5}, {3'b0, prev});
      clk = 1'b1; #1;
      check($sformatf("pipe_edge%0d", i), {3'b0, q5}, {3'b0, vecs[i]});
      #4;
      clk = 1'b0;
      #3;
      prev = vecs[i];
    end

    // Asynchronous clear mid-cycle with clk high
    check("pre_clear_q1", {7'b0, q1}, 8'h01);
    clk = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("mid_clear_q1", {7'b0, q1}, 8'h00);
    check("mid_clear_q5", {3'b0, q5}, 8'h00);
    check("mid_clear_q8", q8, 8'hA5);
    #2;
    clk = 1'b0;
    d1  = 1'b1;
    #2;
    reset = 1'b1;
    #3;
    clk = 1'b1; #1;
    check("post_clear_cap", {7'b0, q1}, 8'h01);

    // Wide instance capture and non-transparency
    #4;
    clk = 1'b0;
    #2;
    d8 = 8'h3C;
    #3;
    clk = 1'b1; #1;
    check("wide_cap", q8, 8'h3C);
    #4;
    clk = 1'b0;
    #2;
    d8 = 8'h00;
    #2;
    check("wide_hold", q8, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
